// File: rtl/fpu_pkg.sv
// Shared FPU issue definitions: opcodes, rounding modes, flag indices, FSM states.
package fpu_pkg;

    localparam int unsigned FUNC7_W = 7;
    localparam int unsigned FUNC3_W = 3;
    localparam int unsigned FLAGS_W = 5;

    localparam logic [FUNC7_W-1:0] FADD_S   = 7'b0000000;
    localparam logic [FUNC7_W-1:0] FADD_D   = 7'b0000001;
    localparam logic [FUNC7_W-1:0] FSUB_S   = 7'b0000100;
    localparam logic [FUNC7_W-1:0] FSUB_D   = 7'b0000101;
    localparam logic [FUNC7_W-1:0] FCMP_S   = 7'b1010000;
    localparam logic [FUNC7_W-1:0] FCMP_D   = 7'b1010001;
    localparam logic [FUNC7_W-1:0] FCVT_D_S = 7'b0100001;
    localparam logic [FUNC7_W-1:0] FCVT_W_S = 7'b1100000;
    localparam logic [FUNC7_W-1:0] FCVT_D_W = 7'b1101001;

    localparam logic [FUNC3_W-1:0] RM_RNE = 3'b000;
    localparam logic [FUNC3_W-1:0] RM_RTZ = 3'b001;
    localparam logic [FUNC3_W-1:0] RM_RDN = 3'b010;
    localparam logic [FUNC3_W-1:0] RM_RUP = 3'b011;
    localparam logic [FUNC3_W-1:0] RM_RMM = 3'b100;
    localparam logic [FUNC3_W-1:0] RM_RSV5 = 3'b101;
    localparam logic [FUNC3_W-1:0] RM_RSV6 = 3'b110;
    localparam logic [FUNC3_W-1:0] RM_DYN = 3'b111;

    localparam int unsigned FLAG_NX = 0;
    localparam int unsigned FLAG_UF = 1;
    localparam int unsigned FLAG_OF = 2;
    localparam int unsigned FLAG_DZ = 3;
    localparam int unsigned FLAG_NV = 4;

    typedef logic [1:0] fsm_state_t;
    localparam fsm_state_t ST_IDLE = 2'd0;
    localparam fsm_state_t ST_EXEC = 2'd1;
    localparam fsm_state_t ST_RESP = 2'd2;

    // Compare ops carry a predicate in func3, not a rounding mode.
    function automatic logic is_cmp(input logic [FUNC7_W-1:0] f7);
        return (f7 == FCMP_S) || (f7 == FCMP_D);
    endfunction

endpackage

// File: rtl/fpu_rm_resolve.sv
// Resolves the dynamic rounding mode and flags reserved modes as illegal.
module fpu_rm_resolve
    import fpu_pkg::*;
(
    input  logic [FUNC7_W-1:0] func7,
    input  logic [FUNC3_W-1:0] func3,
    input  logic [FUNC3_W-1:0] frm,
    output logic [FUNC3_W-1:0] func3_eff_c,
    output logic               illegal_c
);

    always_comb begin
        func3_eff_c = func3;
        illegal_c   = 1'b0;
        if (!is_cmp(func7)) begin
            if (func3 == RM_DYN) begin
                func3_eff_c = frm;
            end
            illegal_c = (func3_eff_c == RM_RSV5) || (func3_eff_c == RM_RSV6);
        end
    end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// FPU issue controller: request/response handshake, frm/fflags ownership.
// Optional: define FPU_ISSUE_NANBOX_EN to NaN-box FADD_S/FSUB_S results.
module fpu_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int unsigned LAT   = 1,
    parameter int unsigned TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [TAG_W-1:0]   req_tag,
    input  logic [6:0]         req_func7,
    input  logic [2:0]         req_func3,
    input  logic [4:0]         req_rs2,
    input  logic [63:0]        req_op_a,
    input  logic [63:0]        req_op_b,
    output logic [6:0]         fpu_func7,
    output logic [2:0]         fpu_func3,
    output logic [4:0]         fpu_rs2,
    output logic [63:0]        fpu_operand_a,
    output logic [63:0]        fpu_operand_b,
    input  logic [63:0]        fpu_result_out,
    input  logic               fpu_flag_invalid,
    input  logic               fpu_flag_divbyzero,
    input  logic               fpu_flag_overflow,
    input  logic               fpu_flag_underflow,
    input  logic               fpu_flag_inexact,
    input  logic               fpu_flag_cmp,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [TAG_W-1:0]   resp_tag,
    output logic [63:0]        resp_result,
    output logic               resp_cmp,
    output logic [4:0]         resp_flags,
    output logic               resp_illegal,
    input  logic               csr_we,
    input  logic [7:0]         csr_wdata,
    output logic [2:0]         csr_frm,
    output logic [4:0]         csr_fflags
);

    localparam int unsigned CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

    fsm_state_t       state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             req_ready_nx, resp_valid_nx, resp_cmp_nx, resp_illegal_nx;
    logic [6:0]       fpu_func7_nx;
    logic [2:0]       fpu_func3_nx, csr_frm_nx;
    logic [4:0]       fpu_rs2_nx, resp_flags_nx, csr_fflags_nx, flags_in;
    logic [63:0]      fpu_operand_a_nx, fpu_operand_b_nx, resp_result_nx, result_cap;
    logic [TAG_W-1:0] resp_tag_nx;
    logic [2:0]       rm_func3_c;
    logic             rm_illegal_c;

    fpu_rm_resolve u_rm_resolve (
        .func7       (req_func7),
        .func3       (req_func3),
        .frm         (csr_frm),
        .func3_eff_c (rm_func3_c),
        .illegal_c   (rm_illegal_c)
    );

    // Flag vector and (optionally NaN-boxed) result presented by the FPU.
    always_comb begin
        flags_in          = '0;
        flags_in[FLAG_NV] = fpu_flag_invalid;
        flags_in[FLAG_DZ] = fpu_flag_divbyzero;
        flags_in[FLAG_OF] = fpu_flag_overflow;
        flags_in[FLAG_UF] = fpu_flag_underflow;
        flags_in[FLAG_NX] = fpu_flag_inexact;
        result_cap        = fpu_result_out;
`ifdef FPU_ISSUE_NANBOX_EN
        if ((fpu_func7 == FADD_S) || (fpu_func7 == FSUB_S)) begin
            result_cap[63:32] = 32'hFFFF_FFFF;
        end
`endif
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nx         = state;
        cnt_nx           = cnt;
        fpu_func7_nx     = fpu_func7;
        fpu_func3_nx     = fpu_func3;
        fpu_rs2_nx       = fpu_rs2;
        fpu_operand_a_nx = fpu_operand_a;
        fpu_operand_b_nx = fpu_operand_b;
        resp_tag_nx      = resp_tag;
        resp_result_nx   = resp_result;
        resp_cmp_nx      = resp_cmp;
        resp_flags_nx    = resp_flags;
        resp_illegal_nx  = resp_illegal;
        csr_frm_nx       = csr_frm;
        csr_fflags_nx    = csr_fflags;

        if (csr_we) begin
            csr_frm_nx    = csr_wdata[7:5];
            csr_fflags_nx = csr_wdata[4:0];
        end

        case (state)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    fpu_func7_nx     = req_func7;
                    fpu_func3_nx     = rm_func3_c;
                    fpu_rs2_nx       = req_rs2;
                    fpu_operand_a_nx = req_op_a;
                    fpu_operand_b_nx = req_op_b;
                    resp_tag_nx      = req_tag;
                    if (rm_illegal_c) begin
                        state_nx        = ST_RESP;
                        resp_illegal_nx = 1'b1;
                        resp_result_nx  = '0;
                        resp_flags_nx   = '0;
                        resp_cmp_nx     = 1'b0;
                    end else begin
                        state_nx = ST_EXEC;
                        cnt_nx   = CNT_W'(LAT - 1);
                    end
                end
            end
            ST_EXEC: begin
                if (cnt == '0) begin
                    resp_result_nx = result_cap;
                    resp_cmp_nx    = fpu_flag_cmp;
                    resp_flags_nx  = flags_in;
                    csr_fflags_nx  = csr_fflags_nx | flags_in;
                    state_nx       = ST_RESP;
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_nx        = ST_IDLE;
                    resp_illegal_nx = 1'b0;
                end
            end
            default: state_nx = ST_IDLE;
        endcase

        req_ready_nx  = (state_nx == ST_IDLE);
        resp_valid_nx = (state_nx == ST_RESP);
    end

    // req_ready stays low through reset and rises on the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            req_ready     <= 1'b0;
            resp_valid    <= 1'b0;
            fpu_func7     <= '0;
            fpu_func3     <= '0;
            fpu_rs2       <= '0;
            fpu_operand_a <= '0;
            fpu_operand_b <= '0;
            resp_tag      <= '0;
            resp_result   <= '0;
            resp_cmp      <= 1'b0;
            resp_flags    <= '0;
            resp_illegal  <= 1'b0;
            csr_frm       <= '0;
            csr_fflags    <= '0;
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            req_ready     <= req_ready_nx;
            resp_valid    <= resp_valid_nx;
            fpu_func7     <= fpu_func7_nx;
            fpu_func3     <= fpu_func3_nx;
            fpu_rs2       <= fpu_rs2_nx;
            fpu_operand_a <= fpu_operand_a_nx;
            fpu_operand_b <= fpu_operand_b_nx;
            resp_tag      <= resp_tag_nx;
            resp_result   <= resp_result_nx;
            resp_cmp      <= resp_cmp_nx;
            resp_flags    <= resp_flags_nx;
            resp_illegal  <= resp_illegal_nx;
            csr_frm       <= csr_frm_nx;
            csr_fflags    <= csr_fflags_nx;
        end
    end

endmodule
